// File: rtl/shared_adder_ctrl.sv
// Two-requester adder controller time-sharing one 4-bit ripple-carry adder nibble-serially.
// Optional subtract mode: define SHARED_ADDER_SUB_EN to add Sub0/Sub1 ports.

module shared_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for a request; arbitration happens here only
// ADD   | one nibble per cycle, LSB first, four cycles total
// DONE  | result valid for one cycle, then back to IDLE
module shared_adder_ctrl (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req0,
  input  logic [15:0] A0,
  input  logic [15:0] B0,
  input  logic        Req1,
  input  logic [15:0] A1,
  input  logic [15:0] B1,
`ifdef SHARED_ADDER_SUB_EN
  input  logic        Sub0,
  input  logic        Sub1,
`endif
  output logic        Gnt0,
  output logic        Gnt1,
  output logic        Busy,
  output logic        Done,
  output logic        DoneId,
  output logic [15:0] S,
  output logic        Co
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t      state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        id_q;
  logic        last_q;
  logic [1:0]  nib_q;
  logic        carry_q;
  logic [11:0] acc_q;
  logic        win;
  logic        win_sub;
  logic        sub_eff;
  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [3:0]  sum_nib;
  logic [4:0]  c;

  // last_q resets to 1 so that Req0 wins the first tie
  assign win = Req1 & (~Req0 | ~last_q);

`ifdef SHARED_ADDER_SUB_EN
  logic sub_q;
  assign win_sub = win ? Sub1 : Sub0;
  assign sub_eff = sub_q;
`else
  assign win_sub = 1'b0;
  assign sub_eff = 1'b0;
`endif

  always_comb begin
    a_nib = a_q[3:0];
    b_nib = b_q[3:0];
    case (nib_q)
      2'd0: begin a_nib = a_q[3:0];   b_nib = b_q[3:0];   end
      2'd1: begin a_nib = a_q[7:4];   b_nib = b_q[7:4];   end
      2'd2: begin a_nib = a_q[11:8];  b_nib = b_q[11:8];  end
      default: begin a_nib = a_q[15:12]; b_nib = b_q[15:12]; end
    endcase
    b_nib = b_nib ^ {4{sub_eff}};
  end

  assign c[0] = carry_q;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_fa
      shared_adder_fa u_fa (
        .a  (a_nib[i]),
        .b  (b_nib[i]),
        .ci (c[i]),
        .s  (sum_nib[i]),
        .co (c[i+1])
      );
    end
  endgenerate

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      nib_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      Gnt0    <= 1'b0;
      Gnt1    <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DoneId  <= 1'b0;
      S       <= '0;
      Co      <= 1'b0;
`ifdef SHARED_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      Gnt0 <= 1'b0;
      Gnt1 <= 1'b0;
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Req0 || Req1) begin
            state   <= ADD;
            Busy    <= 1'b1;
            a_q     <= win ? A1 : A0;
            b_q     <= win ? B1 : B0;
            id_q    <= win;
            last_q  <= win;
            nib_q   <= '0;
            carry_q <= win_sub;
            Gnt0    <= ~win;
            Gnt1    <= win;
`ifdef SHARED_ADDER_SUB_EN
            sub_q   <= win_sub;
`endif
          end
        end
        ADD: begin
          carry_q <= c[4];
          nib_q   <= nib_q + 2'd1;
          case (nib_q)
            2'd0: acc_q[3:0]  <= sum_nib;
            2'd1: acc_q[7:4]  <= sum_nib;
            2'd2: acc_q[11:8] <= sum_nib;
            default: begin
              // outputs are loaded only here so they hold between operations
              state  <= DONE;
              Done   <= 1'b1;
              DoneId <= id_q;
              S      <= {sum_nib, acc_q};
              Co     <= c[4];
            end
          endcase
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shared_adder_ctrl.md
SHARED_ADDER_CTRL -- requirements
Module: shared_adder_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: Clk and Rst_n.
REQ-002 Ports SHALL be, as name direction width meaning:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  async active-low reset.
- Req0  in  1  requester 0 add request, held until Gnt0.
- A0, B0  in  16  requester 0 operands.
- Req1  in  1  requester 1 add request, held until Gnt1.
- A1, B1  in  16  requester 1 operands.
- Gnt0, Gnt1  out  1  one-cycle accept pulse; operands captured.
- Busy  out  1  operation in progress (state != IDLE).
- Done  out  1  one-cycle result-valid pulse.
- DoneId  out  1  requester owning the result, valid with Done.
- S  out  16  sum.
- Co  out  1  carry out of bit 15.
REQ-003 The block SHALL contain exactly one 4-bit ripple-carry adder built from four 1-bit full adders, and SHALL time-share it nibble-serially.

Function
REQ-004 The state machine SHALL have three states: IDLE, ADD and DONE.
REQ-005 IDLE: if any Req is high at a rising edge, the block SHALL go to ADD, latch the winner's A/B and owner ID, clear nibble counter and carry register, and register the winner's Gnt high for exactly the next cycle; with no Req it SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin: a lone requester wins; with both high, the requester not granted last wins.
REQ-007 ADD: each cycle SHALL add nibble k (k = 0..3, LSB first) of the latched operands plus the carry register, and at the edge store the 4-bit result into S-accumulator bits [4k+3:4k] and the nibble carry into the carry register.
REQ-008 After the k = 3 edge the block SHALL enter DONE; Done, DoneId, S and Co SHALL be valid for exactly that one cycle; Done SHALL assert exactly 4 cycles after Gnt asserts.
REQ-009 DONE SHALL always return to IDLE on the next edge, giving an earliest next grant 2 cycles after Done and a minimum of 6 cycles per operation.
REQ-010 Req inputs SHALL be ignored in ADD and DONE; a pending Req SHALL be granted only from IDLE.
REQ-011 S and Co SHALL hold their last values after DONE until the next DONE overwrites them.
REQ-012 Operand changes after the Gnt edge SHALL NOT affect the result in progress.

Reset
REQ-013 Asserting Rst_n low SHALL immediately force: state IDLE; Gnt0, Gnt1, Busy, Done, DoneId and Co = 0; S = 16'h0000; carry and nibble counter = 0; round-robin pointer set so Req0 wins the first tie.
REQ-014 Reset during ADD or DONE SHALL discard the operation, with no Done ever issued for it.

Configuration
REQ-015 With macro SHARED_ADDER_SUB_EN defined, the block SHALL add inputs Sub0 and Sub1 (1 bit each, latched with the operands); when the latched Sub is 1, the block SHALL use the inverted B and an initial carry of 1, computing A - B mod 2^16 with Co = 1 meaning no borrow.
REQ-016 Without SHARED_ADDER_SUB_EN, the Sub0/Sub1 ports SHALL NOT exist and the initial carry SHALL always be 0.

Verification
REQ-017 Req0, A0=16'h1234, B0=16'h0FCD -> Gnt0 one cycle later; Done 4 cycles after Gnt0; S=16'h2201, Co=0, DoneId=0.
REQ-018 Req1, A1=16'hFFFF, B1=16'h0001 -> carry ripples across all nibbles; S=16'h0000, Co=1, DoneId=1.
REQ-019 Req0 and Req1 held high continuously from reset -> grants Gnt0, Gnt1, Gnt0, Gnt1, spaced 6 cycles apart; DoneId alternates 0, 1, 0, 1.
REQ-020 Req1 raised during ADD of a Req0 operation -> no Gnt1 until the IDLE after Done; Gnt1 follows 2 cycles after Done.
REQ-021 Rst_n pulsed low during the 2nd ADD cycle -> Busy=0 and S=16'h0000 immediately; no Done ever appears for that operation.
REQ-022 With SHARED_ADDER_SUB_EN: Sub1=1, A1=16'h0005, B1=16'h0007 -> S=16'hFFFE, Co=0; A1=16'h0007, B1=16'h0005 -> S=16'h0002, Co=1.
